// File: rtl/spike_count_classifier.sv
// Purpose : counts spikes per neuron over WINDOW timesteps, then serially scans for the arg-max neuron.
// Latency : start sampled at edge 0 -> spikes counted on edges 1..WINDOW -> done high after edge WINDOW+NUM_NEURONS+1.
// Backpressure: none; start is accepted only in IDLE with done low, never queued.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   start             request a classification (honoured only when idle)
//   spike_in          one spike bit per neuron per cycle
//   busy / done       busy while a window is in progress; done pulses once per result
//   winner_idx/count  arg-max neuron and its count; no_spikes when every count was 0
//   cnt_sel/cnt_dout  combinational readback of one per-neuron counter (0 when out of range)
module spike_count_classifier #(
    parameter int NUM_NEURONS = 1,
    parameter int WINDOW      = 256,
    parameter int COUNT_WIDTH = 16,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_NEURONS-1:0] spike_in,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       winner_idx,
    output logic [COUNT_WIDTH-1:0] winner_count,
    output logic                   no_spikes,
    input  logic [IDX_W-1:0]       cnt_sel,
    output logic [COUNT_WIDTH-1:0] cnt_dout
);

    localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0]    T_LAST = TW'(WINDOW - 1);
    localparam logic [IDX_W-1:0] J_LAST = IDX_W'(NUM_NEURONS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_SCAN  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]             state;
    logic [TW-1:0]          t;
    logic [IDX_W-1:0]       scan_idx;
    logic [IDX_W-1:0]       best_idx;
    logic [COUNT_WIDTH-1:0] best_cnt;
    logic [COUNT_WIDTH-1:0] scan_cnt;
    logic [COUNT_WIDTH-1:0] cnt [NUM_NEURONS];
    logic                   done_q;
    logic                   start_ok;

    // A start arriving while the previous result is being announced is dropped.
    assign start_ok = (state == S_IDLE) && start && !done_q;

    // DONE is the internal cycle that latches the result; done itself is the
    // registered pulse that follows, so busy drops exactly as done rises.
    assign busy = (state != S_IDLE);
    assign done = done_q;

    // Read muxes built by compare rather than indexing, so out-of-range
    // selects fall through to zero without any array bounds concerns.
    always_comb begin
        scan_cnt = '0;
        cnt_dout = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (scan_idx == IDX_W'(i)) scan_cnt = cnt[i];
            if (cnt_sel == IDX_W'(i))  cnt_dout = cnt[i];
        end
    end

    // Per-neuron saturating counters; cleared only by reset or an accepted start
    // so the last window stays readable afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
        end else if (start_ok) begin
            for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
        end else if (state == S_COUNT) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (spike_in[i] && (cnt[i] != {COUNT_WIDTH{1'b1}}))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            t            <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
            winner_idx   <= '0;
            winner_count <= '0;
            no_spikes    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state <= S_COUNT;
                        t     <= '0;
                    end
                end
                S_COUNT: begin
                    t <= t + 1'b1;
                    if (t == T_LAST) begin
                        state    <= S_SCAN;
                        scan_idx <= '0;
                    end
                end
                S_SCAN: begin
                    // Index 0 seeds the running best; later entries replace it only
                    // on a strictly larger count, so ties keep the lowest index.
                    if (scan_idx == '0) begin
                        best_idx <= '0;
                        best_cnt <= scan_cnt;
                    end else if (scan_cnt > best_cnt) begin
                        best_idx <= scan_idx;
                        best_cnt <= scan_cnt;
                    end
                    if (scan_idx == J_LAST) state <= S_DONE;
                    else                    scan_idx <= scan_idx + 1'b1;
                end
                default: begin // S_DONE
                    winner_idx   <= (best_cnt == '0) ? '0 : best_idx;
                    winner_count <= best_cnt;
                    no_spikes    <= (best_cnt == '0);
                    done_q       <= 1'b1;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Purpose : self-checking bench for spike_count_classifier (table vectors, corner sequences, random windows).
// Latency : expects done exactly WINDOW+NUM_NEURONS+1 edges after the start edge.
// Backpressure: exercises start during busy and during done, both of which must be dropped.
module tb_spike_count_classifier;

    localparam int N1 = 4, W1 = 8,  CW1 = 16;
    localparam int N2 = 2, W2 = 12, CW2 = 3;
    localparam int DONE_K1 = W1 + N1 + 1;
    localparam int DONE_K2 = W2 + N2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start1;
    logic [N1-1:0]  spike1;
    logic           busy1, done1, ns1;
    logic [1:0]     widx1, sel1;
    logic [CW1-1:0] wcnt1, dout1;

    logic           start2;
    logic [N2-1:0]  spike2;
    logic           busy2, done2, ns2;
    logic [0:0]     widx2, sel2;
    logic [CW2-1:0] wcnt2, dout2;

    spike_count_classifier #(.NUM_NEURONS(N1), .WINDOW(W1), .COUNT_WIDTH(CW1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .spike_in(spike1), .busy(busy1), .done(done1),
        .winner_idx(widx1), .winner_count(wcnt1), .no_spikes(ns1), .cnt_sel(sel1), .cnt_dout(dout1));

    spike_count_classifier #(.NUM_NEURONS(N2), .WINDOW(W2), .COUNT_WIDTH(CW2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .spike_in(spike2), .busy(busy2), .done(done2),
        .winner_idx(widx2), .winner_count(wcnt2), .no_spikes(ns2), .cnt_sel(sel2), .cnt_dout(dout2));

    int total = 0;
    int bad   = 0;

    logic [3:0] pat [W1];
    int exp_cnt [N1];
    int exp_idx, exp_wc, exp_ns;

    typedef struct {
        logic [3:0] m_lo;
        logic [3:0] m_hi;
        int split;
        int e_idx;
        int e_cnt;
        int e_ns;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: counts are just column sums of the pattern; winner is the first
    // neuron whose count equals the maximum.
    task automatic model1();
        int mx;
        mx = 0;
        for (int i = 0; i < N1; i++) begin
            exp_cnt[i] = 0;
            for (int c = 0; c < W1; c++) exp_cnt[i] += int'(pat[c][i]);
            if (exp_cnt[i] > mx) mx = exp_cnt[i];
        end
        exp_idx = -1;
        for (int i = 0; i < N1; i++) if (exp_idx < 0 && exp_cnt[i] == mx) exp_idx = i;
        exp_wc = mx;
        exp_ns = (mx == 0);
        if (exp_ns != 0) exp_idx = 0;
    endtask

    // Starts a window on dut1 using pat[], then steps last_k edges recording done/busy timing.
    // With hs set, start is also pulsed in the middle of the window.
    task automatic run1(input int last_k, input bit hs,
                        output int done_at, output int busy_fall, output int n_done);
        done_at = -1; busy_fall = -1; n_done = 0;
        start1 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= last_k; k++) begin
            @(negedge clk);
            start1 = hs && (k == 4);
            if (k <= W1) spike1 = pat[k-1];
            else         spike1 = 4'($urandom);
            @(posedge clk);
            #1;
            if (done1) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (!busy1 && busy_fall < 0) busy_fall = k;
        end
        start1 = 1'b0;
        spike1 = '0;
    endtask

    task automatic check_counts(input string tag);
        for (int s = 0; s < N1; s++) begin
            sel1 = 2'(s);
            #1;
            check($sformatf("%s cnt_dout[%0d]", tag, s), int'(dout1), exp_cnt[s]);
        end
    endtask

    task automatic check_full(input string tag, input int e_idx, input int e_cnt, input int e_ns);
        int da, bf, nd;
        run1(DONE_K1 + 10, 1'b0, da, bf, nd);
        check({tag, " done_at"},   da, DONE_K1);
        check({tag, " busy_fall"}, bf, DONE_K1);
        check({tag, " n_done"},    nd, 1);
        check({tag, " winner_idx"},   int'(widx1), e_idx);
        check({tag, " winner_count"}, int'(wcnt1), e_cnt);
        check({tag, " no_spikes"},    int'(ns1),   e_ns);
        check_counts(tag);
    endtask

    initial begin
        int da, bf, nd, nb;
        logic [3:0] m;

        rst = 1'b0; start1 = 1'b0; spike1 = '0; sel1 = '0;
        start2 = 1'b0; spike2 = '0; sel2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",         int'(busy1), 0);
        check("reset done",         int'(done1), 0);
        check("reset winner_idx",   int'(widx1), 0);
        check("reset winner_count", int'(wcnt1), 0);
        check("reset no_spikes",    int'(ns1),   0);
        check("reset cnt_dout",     int'(dout1), 0);
        rst = 1'b1;
        @(negedge clk);

        // Table vectors: mask m_lo on cycles < split, m_hi afterwards.
        vecs[0] = '{4'b0100, 4'b0100, 8, 2, 8, 0};   // single active neuron
        vecs[1] = '{4'b1010, 4'b0000, 5, 1, 5, 0};   // tie between 1 and 3
        vecs[2] = '{4'b0000, 4'b0000, 8, 0, 0, 1};   // silence
        vecs[3] = '{4'b1111, 4'b1111, 8, 0, 8, 0};   // all equal
        vecs[4] = '{4'b1001, 4'b1000, 7, 3, 8, 0};   // highest index wins strictly
        vecs[5] = '{4'b0001, 4'b0110, 3, 1, 5, 0};   // three-way mix with tie
        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < W1; c++) pat[c] = (c < vecs[v].split) ? vecs[v].m_lo : vecs[v].m_hi;
            model1();
            check_full($sformatf("vec%0d", v), vecs[v].e_idx, vecs[v].e_cnt, vecs[v].e_ns);
        end

        // Handshake: start mid-window and during done are dropped; one cycle later is accepted.
        for (int c = 0; c < W1; c++) pat[c] = 4'b0001;
        run1(DONE_K1, 1'b1, da, bf, nd);
        check("hs done_at", da, DONE_K1);
        check("hs n_done",  nd, 1);
        check("hs winner_count", int'(wcnt1), 8);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        check("hs start at done busy", int'(busy1), 0);
        check("hs done falls",         int'(done1), 0);
        sel1 = 2'd0;
        #1;
        check("hs counts held", int'(dout1), 8);
        for (int c = 0; c < W1; c++) pat[c] = 4'b1000;
        model1();
        check_full("hs restart", 3, 8, 0);

        // Reset mid-window: everything clears, no done appears.
        for (int c = 0; c < W1; c++) pat[c] = 4'b1111;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        spike1 = 4'b1111;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        sel1 = 2'd0;
        #1;
        check("midrst busy",         int'(busy1), 0);
        check("midrst done",         int'(done1), 0);
        check("midrst winner_idx",   int'(widx1), 0);
        check("midrst winner_count", int'(wcnt1), 0);
        check("midrst no_spikes",    int'(ns1),   0);
        check("midrst cnt_dout",     int'(dout1), 0);
        @(negedge clk);
        rst = 1'b1;
        nd = 0; nb = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            spike1 = 4'($urandom);
            @(posedge clk);
            #1;
            if (done1) nd++;
            if (busy1) nb++;
        end
        spike1 = '0;
        check("midrst no done", nd, 0);
        check("midrst idle",    nb, 0);

        // Saturation on the narrow instance: neuron 0 spikes 12 times into a 3-bit counter.
        da = -1;
        start2 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= DONE_K2 + 5; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            spike2 = (k <= 5) ? 2'b11 : ((k <= W2) ? 2'b01 : 2'b00);
            @(posedge clk);
            #1;
            if (done2 && da < 0) da = k;
        end
        check("sat done_at",      da, DONE_K2);
        check("sat winner_idx",   int'(widx2), 0);
        check("sat winner_count", int'(wcnt2), 7);
        check("sat no_spikes",    int'(ns2),   0);
        sel2 = 1'b0;
        #1;
        check("sat cnt_dout[0]", int'(dout2), 7);
        sel2 = 1'b1;
        #1;
        check("sat cnt_dout[1]", int'(dout2), 5);

        // Random windows against the reference model.
        for (int r = 0; r < 20; r++) begin
            m = 4'($urandom);
            for (int c = 0; c < W1; c++) pat[c] = 4'($urandom) & m;
            model1();
            check_full($sformatf("rnd%0d", r), exp_idx, exp_wc, exp_ns);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
